// File: rtl/code_loader.sv
// Boot-time program loader: packs a little-endian byte stream into instruction
// words, writes them into code_ram, and holds the processor in reset until the
// whole image has been written.
module code_loader #(
  parameter int unsigned ADDR_SIZE = 18,
  parameter int unsigned WORD_SIZE = 18,
  parameter int unsigned MEM_SIZE  = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  input  logic                 start,
  output logic                 code_we,
  output logic [ADDR_SIZE-1:0] code_addr,
  output logic [WORD_SIZE-1:0] code_din,
  output logic                 complete_fill_ram,
  output logic                 processor_reset,
  output logic                 overflow
);

  localparam int unsigned CNT_W  = 18;
  localparam int unsigned CNT_W1 = CNT_W + 1;
  localparam int unsigned B2_W   = WORD_SIZE - 16;
  localparam int unsigned LB2_W  = CNT_W - 16;
  localparam logic [CNT_W:0] MEM_LIM = CNT_W1'(MEM_SIZE);

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [1:0]           byte_idx_q;
  logic [7:0]           b0_q;
  logic [7:0]           b1_q;
  logic [CNT_W-1:0]     len_q;
  logic [CNT_W-1:0]     word_cnt_q;
  logic                 done_pend_q;
  logic                 rx_ready_q;
  logic                 code_we_q;
  logic [ADDR_SIZE-1:0] code_addr_q;
  logic [WORD_SIZE-1:0] code_din_q;
  logic                 complete_q;
  logic                 proc_reset_q;
  logic                 overflow_q;

  logic                 xfer_c;
  logic                 third_c;
  logic                 in_range_c;
  logic                 last_c;
  logic [WORD_SIZE-1:0] word_c;
  logic [CNT_W-1:0]     len_c;
  logic [CNT_W-1:0]     cnt_inc_c;
  logic                 unused_rx_c;

  // Byte handshake decode and little-endian word/length assembly
  assign xfer_c      = rx_valid & rx_ready_q;
  assign third_c     = xfer_c & (byte_idx_q == 2'd2);
  assign word_c      = {rx_data[B2_W-1:0], b1_q, b0_q};
  assign len_c       = {rx_data[LB2_W-1:0], b1_q, b0_q};
  assign cnt_inc_c   = word_cnt_q + CNT_W'(1);
  assign in_range_c  = ({1'b0, word_cnt_q} < MEM_LIM);
  assign last_c      = (cnt_inc_c == len_q);
  assign unused_rx_c = ^rx_data;

  // Loader FSM with registered outputs; done_pend_q delays completion by one
  // cycle so complete_fill_ram follows the last code_we pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_LEN;
      byte_idx_q   <= 2'd0;
      b0_q         <= 8'd0;
      b1_q         <= 8'd0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      done_pend_q  <= 1'b0;
      rx_ready_q   <= 1'b0;
      code_we_q    <= 1'b0;
      code_addr_q  <= '0;
      code_din_q   <= '0;
      complete_q   <= 1'b0;
      proc_reset_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      code_we_q <= 1'b0;

      if (xfer_c) begin
        byte_idx_q <= (byte_idx_q == 2'd2) ? 2'd0 : byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd0) b0_q <= rx_data;
        if (byte_idx_q == 2'd1) b1_q <= rx_data;
      end

      case (state_q)
        S_LEN: begin
          rx_ready_q <= 1'b1;
          if (third_c) begin
            if (len_c == '0) begin
              state_q      <= S_DONE;
              rx_ready_q   <= 1'b0;
              complete_q   <= 1'b1;
              proc_reset_q <= 1'b0;
            end else begin
              state_q    <= S_DATA;
              len_q      <= len_c;
              word_cnt_q <= '0;
            end
          end
        end

        S_DATA: begin
          if (done_pend_q) begin
            state_q      <= S_DONE;
            done_pend_q  <= 1'b0;
            complete_q   <= 1'b1;
            proc_reset_q <= 1'b0;
          end else if (third_c) begin
            if (in_range_c) begin
              code_we_q   <= 1'b1;
              code_addr_q <= ADDR_SIZE'(word_cnt_q);
              code_din_q  <= word_c;
            end else begin
              overflow_q <= 1'b1;
            end
            word_cnt_q <= cnt_inc_c;
            if (last_c) begin
              done_pend_q <= 1'b1;
              rx_ready_q  <= 1'b0;
            end
          end
        end

        S_DONE: begin
          rx_ready_q <= 1'b0;
          if (start) begin
            state_q      <= S_LEN;
            complete_q   <= 1'b0;
            proc_reset_q <= 1'b1;
            overflow_q   <= 1'b0;
            byte_idx_q   <= 2'd0;
            word_cnt_q   <= '0;
            rx_ready_q   <= 1'b1;
          end
        end

        default: state_q <= S_LEN;
      endcase
    end
  end

  assign rx_ready          = rx_ready_q;
  assign code_we           = code_we_q;
  assign code_addr         = code_addr_q;
  assign code_din          = code_din_q;
  assign complete_fill_ram = complete_q;
  assign processor_reset   = proc_reset_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_code_loader.sv
// Directed bench for code_loader with a small code_ram depth (MEM_SIZE=4).
module tb_code_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        start;
  logic        code_we;
  logic [17:0] code_addr;
  logic [17:0] code_din;
  logic        complete_fill_ram;
  logic        processor_reset;
  logic        overflow;

  int passed = 0;
  int total  = 0;

  logic [7:0]  stream_q[$];
  logic [17:0] wa_q[$];
  logic [17:0] wd_q[$];
  logic [17:0] ea[8];
  logic [17:0] ed[8];
  int          base;

  code_loader #(.ADDR_SIZE(18), .WORD_SIZE(18), .MEM_SIZE(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .rx_ready          (rx_ready),
    .start             (start),
    .code_we           (code_we),
    .code_addr         (code_addr),
    .code_din          (code_din),
    .complete_fill_ram (complete_fill_ram),
    .processor_reset   (processor_reset),
    .overflow          (overflow)
  );

  always #5 clock = ~clock;

  // Record every code_ram write (code_we is sampled once per cycle)
  always @(negedge clock) begin
    if (code_we === 1'b1) begin
      wa_q.push_back(code_addr);
      wd_q.push_back(code_din);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present one byte at a negedge and hold it until a transfer happens
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("rx_ready_timeout", 32'(n), 32'(0));
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input bit gaps);
    foreach (stream_q[i]) begin
      if (gaps) repeat ($urandom_range(0, 5)) @(negedge clock);
      send_byte(stream_q[i]);
    end
  endtask

  task automatic check_writes(input string tag, input int from, input int n);
    chk({tag, "_count"}, 32'(wa_q.size() - from), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (from + i < wa_q.size()) begin
        chk({tag, "_addr"}, 32'(wa_q[from+i]), 32'(ea[i]));
        chk({tag, "_din"},  32'(wd_q[from+i]), 32'(ed[i]));
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("reload_rx_ready", 32'(rx_ready), 32'(1));
    chk("reload_preset", 32'(processor_reset), 32'(1));
    chk("reload_complete", 32'(complete_fill_ram), 32'(0));
    chk("reload_overflow", 32'(overflow), 32'(0));
  endtask

  task automatic load_test2_stream();
    stream_q = '{8'h03, 8'h00, 8'h00, 8'h11, 8'h22, 8'h03,
                 8'h44, 8'h55, 8'h00, 8'hFF, 8'hFF, 8'h03};
    ea[0] = 18'd0; ed[0] = 18'h32211;
    ea[1] = 18'd1; ed[1] = 18'h05544;
    ea[2] = 18'd2; ed[2] = 18'h3FFFF;
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    start    = 1'b0;

    // 1: reset values, rx_ready one clock after release
    repeat (3) @(negedge clock);
    chk("rst_rx_ready", 32'(rx_ready), 32'(0));
    chk("rst_code_we", 32'(code_we), 32'(0));
    chk("rst_code_addr", 32'(code_addr), 32'(0));
    chk("rst_code_din", 32'(code_din), 32'(0));
    chk("rst_complete", 32'(complete_fill_ram), 32'(0));
    chk("rst_preset", 32'(processor_reset), 32'(1));
    chk("rst_overflow", 32'(overflow), 32'(0));
    reset = 1'b0;
    #1;
    chk("rel_rx_ready_early", 32'(rx_ready), 32'(0));
    @(negedge clock);
    chk("rel_rx_ready", 32'(rx_ready), 32'(1));

    // 2: three-word image, write latency and completion timing
    load_test2_stream();
    base = wa_q.size();
    send_stream(1'b0);
    chk("t2_last_we", 32'(code_we), 32'(1));
    chk("t2_complete_early", 32'(complete_fill_ram), 32'(0));
    chk("t2_preset_early", 32'(processor_reset), 32'(1));
    @(negedge clock);
    chk("t2_we_drop", 32'(code_we), 32'(0));
    chk("t2_complete", 32'(complete_fill_ram), 32'(1));
    chk("t2_preset", 32'(processor_reset), 32'(0));
    chk("t2_rx_ready", 32'(rx_ready), 32'(0));
    chk("t2_addr_hold", 32'(code_addr), 32'(2));
    chk("t2_din_hold", 32'(code_din), 32'(18'h3FFFF));
    check_writes("t2", base, 3);

    // 3: zero-length image completes one clock after the third byte
    pulse_start();
    stream_q = '{8'h00, 8'h00, 8'h00};
    base = wa_q.size();
    send_stream(1'b0);
    chk("t3_complete", 32'(complete_fill_ram), 32'(1));
    chk("t3_preset", 32'(processor_reset), 32'(0));
    chk("t3_rx_ready", 32'(rx_ready), 32'(0));
    repeat (2) @(negedge clock);
    chk("t3_no_writes", 32'(wa_q.size() - base), 32'(0));

    // 4: five words into a four-word RAM
    pulse_start();
    stream_q = '{8'h05, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00,
                 8'h03, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      ea[i] = 18'(i);
      ed[i] = 18'(i + 1);
    end
    base = wa_q.size();
    send_stream(1'b0);
    repeat (2) @(negedge clock);
    chk("t4_overflow", 32'(overflow), 32'(1));
    chk("t4_complete", 32'(complete_fill_ram), 32'(1));
    chk("t4_preset", 32'(processor_reset), 32'(0));
    check_writes("t4", base, 4);

    // 5: test 2 image with random idle gaps
    pulse_start();
    load_test2_stream();
    base = wa_q.size();
    send_stream(1'b1);
    repeat (2) @(negedge clock);
    chk("t5_complete", 32'(complete_fill_ram), 32'(1));
    check_writes("t5", base, 3);

    // 6: reset after the second data byte, reload, then restart with length 0
    pulse_start();
    stream_q = '{8'h03, 8'h00, 8'h00, 8'h11, 8'h22};
    send_stream(1'b0);
    reset = 1'b1;
    #1;
    chk("t6_rst_rx_ready", 32'(rx_ready), 32'(0));
    chk("t6_rst_preset", 32'(processor_reset), 32'(1));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    load_test2_stream();
    base = wa_q.size();
    send_stream(1'b0);
    @(negedge clock);
    chk("t6_complete", 32'(complete_fill_ram), 32'(1));
    check_writes("t6", base, 3);
    pulse_start();
    stream_q = '{8'h00, 8'h00, 8'h00};
    send_stream(1'b0);
    chk("t6_recomplete", 32'(complete_fill_ram), 32'(1));
    chk("t6_represet", 32'(processor_reset), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
